// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation step scheduler.
package sim_pkg;

    localparam int unsigned FXP_W           = 32;
    localparam int unsigned STEP_W          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_WAIT     = 3'd2,
        ST_EXCHANGE = 3'd3,
        ST_SAMPLE   = 3'd4,
        ST_ERROR    = 3'd5
    } state_e;

endpackage

// File: rtl/sim_step_scheduler_if.sv
// Control, column and sample-handshake bundle of the step scheduler.
interface sim_step_if
    import sim_pkg::*;
#(
    parameter int unsigned N_COLS = 30
) ();

    logic                run;
    logic                single_step;
    logic [STEP_W-1:0]   max_steps;
    logic                clear_err;
    logic [N_COLS-1:0]   col_flag;
    logic                col_start;
    logic                exch_en;
    logic                sample_valid;
    logic                sample_ready;
    logic [STEP_W-1:0]   step_count;
    logic                step_done;
    logic                busy;
    logic                err;

    modport slave (
        input  run, single_step, max_steps, clear_err, col_flag, sample_ready,
        output col_start, exch_en, sample_valid, step_count, step_done, busy, err
    );

    modport master (
        output run, single_step, max_steps, clear_err, col_flag, sample_ready,
        input  col_start, exch_en, sample_valid, step_count, step_done, busy, err
    );

endinterface

// File: rtl/wdog_counter.sv
// Watchdog for the WAIT phase: counts enabled cycles, flags the last allowed one.
module wdog_counter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expired on the cycle that would bring the count up to TIMEOUT.
    assign expired_c = enable && (count_q >= CNT_W'(TIMEOUT - 1));

    // Next count: clear wins, then increment while enabled and not yet expired.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sim_step_scheduler.sv
// Sequences launch / wait / exchange / sample timesteps across the column array.
module sim_step_scheduler
    import sim_pkg::*;
#(
    parameter int unsigned N_COLS  = 30,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    sim_step_if.slave sif
);

    state_e              state_q, state_d;
    logic                ss_mode_q, ss_mode_d;
    logic [STEP_W-1:0]   max_q, max_d;
    logic [STEP_W-1:0]   step_count_q, step_count_d;
    logic                first_wait_q, first_wait_d;
    logic                col_start_q, col_start_d;
    logic                exch_en_q, exch_en_d;
    logic                sample_valid_q, sample_valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [N_COLS-1:0]   col_flag_c;
    logic                all_done_c;
    logic                wdog_clr_c;
    logic                wdog_en_c;
    logic                wdog_expired_c;
    logic                step_done_c;

    assign col_flag_c  = sif.col_flag;
    assign all_done_c  = &col_flag_c;
    assign wdog_clr_c  = (state_q == ST_LAUNCH);
    assign wdog_en_c   = (state_q == ST_WAIT);
    // Handshake pulse; gated by reset so no accept is reported during a reset cycle.
    assign step_done_c = reset && sample_valid_q && sif.sample_ready;

    wdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (wdog_clr_c),
        .enable    (wdog_en_c),
        .expired_c (wdog_expired_c)
    );

    // Next-state, step bookkeeping and registered-output decode.
    always_comb begin
        state_d      = state_q;
        ss_mode_d    = ss_mode_q;
        max_d        = max_q;
        step_count_d = step_count_q;

        case (state_q)
            ST_IDLE: begin
                if (sif.run || sif.single_step) begin
                    state_d   = ST_LAUNCH;
                    ss_mode_d = sif.single_step && !sif.run;
                    max_d     = sif.max_steps;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Flags are stale on the first WAIT cycle while columns clear them.
                if (!first_wait_q) begin
                    if (all_done_c) begin
                        state_d = ST_EXCHANGE;
                    end else if (wdog_expired_c) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_EXCHANGE: begin
                state_d = ST_SAMPLE;
                if (step_count_q != '1) begin
                    step_count_d = step_count_q + STEP_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (sif.sample_ready) begin
                    if (ss_mode_q || !sif.run ||
                        ((max_q != '0) && (step_count_q == max_q))) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_ERROR: begin
                if (sif.clear_err) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        first_wait_d   = (state_q == ST_LAUNCH);
        col_start_d    = (state_d == ST_LAUNCH);
        exch_en_d      = (state_d == ST_EXCHANGE);
        sample_valid_d = (state_d == ST_SAMPLE);
        err_d          = (state_d == ST_ERROR);
        busy_d         = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            ss_mode_q      <= 1'b0;
            max_q          <= '0;
            step_count_q   <= '0;
            first_wait_q   <= 1'b0;
            col_start_q    <= 1'b0;
            exch_en_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ss_mode_q      <= ss_mode_d;
            max_q          <= max_d;
            step_count_q   <= step_count_d;
            first_wait_q   <= first_wait_d;
            col_start_q    <= col_start_d;
            exch_en_q      <= exch_en_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign sif.col_start    = col_start_q;
    assign sif.exch_en      = exch_en_q;
    assign sif.sample_valid = sample_valid_q;
    assign sif.step_count   = step_count_q;
    assign sif.step_done    = step_done_c;
    assign sif.busy         = busy_q;
    assign sif.err          = err_q;

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Directed bench for sim_step_scheduler with a 4-column flag model.
module tb_sim_step_scheduler;

    logic clk;
    logic reset;

    sim_step_if #(.N_COLS(4)) sif ();

    sim_step_scheduler #(
        .N_COLS  (4),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_exch   = 0;
    int n_done   = 0;
    int n_wait   = 0;

    int       flag_delay = 5;
    int       fcnt       = 0;
    bit       stuck      = 0;
    logic [3:0] flags    = 4'b0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column model: flags drop on col_start, all rise flag_delay cycles later.
    always @(posedge clk) begin
        if (!reset) begin
            flags <= 4'b0000;
            fcnt  <= 0;
        end else if (sif.col_start) begin
            flags <= 4'b0000;
            fcnt  <= flag_delay;
        end else if (fcnt != 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) flags <= 4'b1111;
        end
    end
    assign sif.col_flag = stuck ? 4'b0111 : flags;

    // Pulse counters over the cycle that just ended.
    always @(posedge clk) begin
        if (sif.col_start) n_start++;
        if (sif.exch_en)   n_exch++;
        if (sif.step_done) n_done++;
        if (sif.busy && !sif.col_start && !sif.exch_en && !sif.sample_valid) n_wait++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_start = 0;
        n_exch  = 0;
        n_done  = 0;
        n_wait  = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clr_counts();
    endtask

    // which: 0 busy low, 1 sample_valid high, 2 n_start >= target, 3 err high.
    task automatic wait_cond(input string tag, input int which, input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = !sif.busy;
                1:       ok = sif.sample_valid;
                2:       ok = (n_start >= target);
                default: ok = sif.err;
            endcase
            if (ok) break;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset            = 1'b0;
        sif.run          = 1'b0;
        sif.single_step  = 1'b0;
        sif.max_steps    = 32'd0;
        sif.clear_err    = 1'b0;
        sif.sample_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_busy",  32'(sif.busy), 32'd0);
        chk("rst_err",   32'(sif.err), 32'd0);
        chk("rst_start", 32'(sif.col_start), 32'd0);
        chk("rst_valid", 32'(sif.sample_valid), 32'd0);
        chk("rst_count", sif.step_count, 32'd0);
        reset = 1'b1;
        clr_counts();

        // Single-step pulse
        sif.single_step = 1'b1;
        @(negedge clk);
        sif.single_step = 1'b0;
        chk("ss_busy",  32'(sif.busy), 32'd1);
        chk("ss_start", 32'(sif.col_start), 32'd1);
        wait_cond("ss_idle", 0, 0, 40);
        repeat (3) @(negedge clk);
        chk("ss_nstart", 32'(n_start), 32'd1);
        chk("ss_nexch",  32'(n_exch), 32'd1);
        chk("ss_ndone",  32'(n_done), 32'd1);
        chk("ss_count",  sif.step_count, 32'd1);
        chk("ss_busy0",  32'(sif.busy), 32'd0);

        // run with max_steps=3
        do_reset();
        sif.max_steps = 32'd3;
        sif.run = 1'b1;
        @(negedge clk);
        chk("ms_busy", 32'(sif.busy), 32'd1);
        wait_cond("ms_idle", 0, 0, 100);
        sif.run = 1'b0;
        repeat (4) @(negedge clk);
        chk("ms_nexch",  32'(n_exch), 32'd3);
        chk("ms_nstart", 32'(n_start), 32'd3);
        chk("ms_count",  sif.step_count, 32'd3);
        chk("ms_busy0",  32'(sif.busy), 32'd0);
        sif.max_steps = 32'd0;

        // Watchdog timeout with one column stuck
        do_reset();
        stuck = 1'b1;
        sif.single_step = 1'b1;
        @(negedge clk);
        sif.single_step = 1'b0;
        wait_cond("to_err_seen", 3, 0, 40);
        chk("to_nwait", 32'(n_wait), 32'd16);
        chk("to_busy",  32'(sif.busy), 32'd0);
        sif.run = 1'b1;
        repeat (3) @(negedge clk);
        chk("to_sticky", 32'(sif.err), 32'd1);
        chk("to_nostart", 32'(n_start), 32'd1);
        sif.run = 1'b0;
        sif.clear_err = 1'b1;
        stuck = 1'b0;
        @(negedge clk);
        sif.clear_err = 1'b0;
        chk("to_clr_err",  32'(sif.err), 32'd0);
        chk("to_clr_busy", 32'(sif.busy), 32'd0);
        chk("to_count",    sif.step_count, 32'd0);

        // Backpressure in SAMPLE
        do_reset();
        sif.sample_ready = 1'b0;
        sif.run = 1'b1;
        wait_cond("bp_valid", 1, 0, 40);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(sif.sample_valid), 32'd1);
            chk("bp_hold_count", sif.step_count, 32'd1);
            @(negedge clk);
        end
        chk("bp_nstart", 32'(n_start), 32'd1);
        chk("bp_ndone",  32'(n_done), 32'd0);
        sif.run = 1'b0;
        sif.sample_ready = 1'b1;
        wait_cond("bp_idle", 0, 0, 10);
        chk("bp_ndone1", 32'(n_done), 32'd1);
        chk("bp_count",  sif.step_count, 32'd1);

        // run dropped during WAIT of step 2
        do_reset();
        sif.run = 1'b1;
        wait_cond("rd_start2", 2, 2, 60);
        @(negedge clk);
        sif.run = 1'b0;
        wait_cond("rd_idle", 0, 0, 40);
        repeat (2) @(negedge clk);
        chk("rd_count",  sif.step_count, 32'd2);
        chk("rd_nexch",  32'(n_exch), 32'd2);
        chk("rd_nstart", 32'(n_start), 32'd2);

        // Reset asserted during WAIT
        clr_counts();
        sif.run = 1'b1;
        wait_cond("mr_start", 2, 1, 20);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_busy",  32'(sif.busy), 32'd0);
        chk("mr_start0", 32'(sif.col_start), 32'd0);
        chk("mr_exch",  32'(sif.exch_en), 32'd0);
        chk("mr_valid", 32'(sif.sample_valid), 32'd0);
        chk("mr_err",   32'(sif.err), 32'd0);
        chk("mr_count", sif.step_count, 32'd0);
        sif.run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_nexch", 32'(n_exch), 32'd0);
        chk("mr_ndone", 32'(n_done), 32'd0);
        chk("mr_idle",  32'(sif.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_step_scheduler.md
SIM_STEP_SCHEDULER -- requirements
Module: sim_step_scheduler

Interface
REQ-001 Parameter N_COLS, default 30, number of column instances sequenced.
REQ-002 Parameter TIMEOUT, default 1024, max WAIT cycles before fault.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 run  input  1  level; continuous stepping while high.
REQ-006 single_step  input  1  pulse; requests exactly one timestep from IDLE.
REQ-007 max_steps  input  32  step limit; 0 = unlimited; sampled on leaving IDLE.
REQ-008 col_flag  input  N_COLS  per-column done flags.
REQ-009 col_start  output  1  broadcast start to all columns.
REQ-010 exch_en  output  1  one-cycle strobe latching neighbour values (u_left/u_right registers).
REQ-011 sample_valid  output  1  step result available.
REQ-012 sample_ready  input  1  consumer accepts sample.
REQ-013 step_count  output  32  completed timesteps.
REQ-014 busy  output  1  high in every state except IDLE and ERROR.
REQ-015 step_done  output  1  one-cycle pulse per accepted sample.
REQ-016 err  output  1  watchdog fault, sticky.
REQ-017 clear_err  input  1  leaves ERROR.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT, EXCHANGE, SAMPLE, ERROR; encoding one-hot or binary, implementer's choice.
REQ-019 IDLE: if run or single_step -> LAUNCH; latch single-step mode = single_step & ~run; latch max_steps; run has priority when both high.
REQ-020 LAUNCH: col_start=1 for exactly one cycle; watchdog cleared; -> WAIT.
REQ-021 WAIT: col_flag ignored on first WAIT cycle (columns clearing flags); thereafter &col_flag=1 -> EXCHANGE.
REQ-022 WAIT: watchdog increments each cycle; reaching TIMEOUT without all flags -> ERROR; completion and timeout in same cycle: completion wins.
REQ-023 EXCHANGE: exch_en=1 one cycle; step_count increments, saturating at 32'hFFFF_FFFF; -> SAMPLE.
REQ-024 SAMPLE: sample_valid=1 held, step_count stable, until sample_ready; valid never drops without ready.
REQ-025 On sample_valid & sample_ready: step_done=1 that cycle; next state IDLE if single-step mode, run=0, or (latched max_steps!=0 and step_count==latched max_steps); else LAUNCH.
REQ-026 run deasserted mid-step: current step completes through SAMPLE, then IDLE.
REQ-027 step_count not cleared on returning to IDLE; cleared only by reset.
REQ-028 ERROR: err=1, busy=0, col_start=0, exch_en=0; clear_err -> IDLE with err=0 next cycle; run/single_step ignored.
REQ-029 Latency: LAUNCH to EXCHANGE minimum 3 cycles; col_start to first possible exch_en 3 cycles.

Reset
REQ-030 reset=0 at posedge: state IDLE, step_count=0, err=0, col_start=0, exch_en=0, sample_valid=0, step_done=0, busy=0, watchdog=0.
REQ-031 Reset mid-operation (any state) aborts immediately to REQ-030 values; no partial exch_en or step_done emitted.

Structure
REQ-032 State enumeration and default TIMEOUT in shared package sim_pkg alongside fixed-point width constant (32).
REQ-033 Watchdog counter as sub-module wdog_counter (clear, enable, expired output).
REQ-034 No arithmetic on node data in this block; fixed-point datapath remains in column modules.

Verification
REQ-035 N_COLS=4, single_step pulse, flags all set 5 cycles after col_start, ready=1 -> one col_start, one exch_en, step_count=1, step_done once, back to IDLE.
REQ-036 run=1, max_steps=3, ready=1 -> exactly 3 exch_en pulses, step_count=3, busy falls, IDLE.
REQ-037 TIMEOUT=16, col_flag=4'b0111 held -> ERROR after 16 WAIT cycles, err=1; clear_err -> IDLE, err=0.
REQ-038 sample_ready low 10 cycles in SAMPLE -> sample_valid held 10 cycles, step_count stable, no new col_start.
REQ-039 run dropped during WAIT of step 2 -> step 2 finishes, step_count=2, IDLE.
REQ-040 reset=0 asserted in WAIT -> next cycle all outputs at reset values, step_count=0.
